// File: rtl/id_hazard_ctrl.sv
// Scoreboard-based stall/flush controller beside the ID stage of a 5-stage MIPS pipeline.
// Optional macro HAZARD_FWD_EN: EX/MEM forwarding present (ALU latency 0, load latency 1).
module id_hazard_ctrl #(
    parameter int unsigned ALU_LAT  = 3,
    parameter int unsigned LOAD_LAT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [5:0]       id_op,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic [5:0]       id_funct,
    input  logic             ex_flush,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    // Countdowns are 2 bits wide, so latencies above 3 are clamped.
`ifdef HAZARD_FWD_EN
    localparam logic [1:0] LAT_ALU  = 2'd0;
    localparam logic [1:0] LAT_LOAD = 2'd1;
`else
    localparam logic [1:0] LAT_ALU  = (ALU_LAT  > 3) ? 2'd3 : 2'(ALU_LAT);
    localparam logic [1:0] LAT_LOAD = (LOAD_LAT > 3) ? 2'd3 : 2'(LOAD_LAT);
`endif

    function automatic logic [1:0] lat_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       r_pend [32];
    logic [CNT_W-1:0] r_stall_cnt;

    logic             w_uses_rs;
    logic             w_uses_rt;
    logic [4:0]       w_dst;
    logic             w_is_load;
    logic             w_rs_busy;
    logic             w_rt_busy;
    logic             w_hazard;
    logic             w_stall;
    logic             w_issue;
    logic [1:0]       w_lat;
    logic [1:0]       w_pend_nxt [32];

    always_comb begin
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_dst     = 5'd0;
        w_is_load = 1'b0;
        case (id_op)
            OP_RTYPE: begin
                w_uses_rs = 1'b1;
                if (id_funct != FN_JR) begin
                    w_uses_rt = 1'b1;
                    w_dst     = id_rd;
                end
            end
            OP_LW: begin
                w_uses_rs = 1'b1;
                w_dst     = id_rt;
                w_is_load = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
                w_uses_rs = 1'b1;
                w_dst     = id_rt;
            end
            OP_JAL: begin
                w_dst = 5'd31;
            end
            default: begin
                w_uses_rs = 1'b0;
            end
        endcase
    end

    // $0 is hardwired, so it never blocks a reader even if its field matches.
    assign w_rs_busy = w_uses_rs && (id_rs != 5'd0) && (r_pend[id_rs] != 2'd0);
    assign w_rt_busy = w_uses_rt && (id_rt != 5'd0) && (r_pend[id_rt] != 2'd0);
    assign w_hazard  = id_valid && (w_rs_busy || w_rt_busy);
    assign w_stall   = w_hazard && !ex_flush;
    assign w_issue   = id_valid && !w_hazard && !ex_flush;
    assign w_lat     = w_is_load ? LAT_LOAD : LAT_ALU;

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_pend_nxt[i] = (r_pend[i] != 2'd0) ? r_pend[i] - 2'd1 : 2'd0;
        end
        if (w_issue && (w_dst != 5'd0)) begin
            w_pend_nxt[w_dst] = lat_max(w_pend_nxt[w_dst], w_lat);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_pend[i] <= 2'd0;
            end
            r_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                r_pend[i] <= w_pend_nxt[i];
            end
            if (w_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign pc_write    = !w_stall;
    assign ifid_write  = !w_stall;
    assign ifid_flush  = ex_flush;
    assign idex_bubble = w_stall || ex_flush || !id_valid;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed-vector bench for id_hazard_ctrl with a queue scoreboard and a negedge monitor.
// Follows HAZARD_FWD_EN for the expected stall counts.
module tb_id_hazard_ctrl;

    // A narrow counter reaches saturation in a few hundred cycles.
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

`ifdef HAZARD_FWD_EN
    localparam int ALU_STALLS  = 0;
    localparam int LOAD_STALLS = 1;
    localparam int J_SW_STALLS = 0;
    localparam int KEEP_STALLS = 0;
    localparam int WAW_STALLS  = 0;
`else
    localparam int ALU_STALLS  = 3;
    localparam int LOAD_STALLS = 3;
    localparam int J_SW_STALLS = 2;
    localparam int KEEP_STALLS = 1;
    localparam int WAW_STALLS  = 3;
`endif

    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [5:0] fn;
    } instr_t;

    typedef struct {
        int             idx;
        logic           pc_write;
        logic           ifid_write;
        logic           ifid_flush;
        logic           idex_bubble;
        logic [CNT_W-1:0] stall_cnt;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             id_valid;
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [5:0]       id_funct;
    logic             ex_flush;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_idx = 0;
    int   m_cnt    = 0;

    id_hazard_ctrl #(.ALU_LAT(3), .LOAD_LAT(3), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_op      (id_op),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_funct   (id_funct),
        .ex_flush   (ex_flush),
        .pc_write   (pc_write),
        .ifid_write (ifid_write),
        .ifid_flush (ifid_flush),
        .idex_bubble(idex_bubble),
        .stall_cnt  (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic instr_t mk(input logic [5:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd,
                                  input logic [5:0] fn);
        instr_t r;
        r.op = op; r.rs = rs; r.rt = rt; r.rd = rd; r.fn = fn;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // One ID cycle: drive inputs after the edge and queue the hand-derived response.
    task automatic step(input logic rst_v, input logic vld, input instr_t ins,
                        input logic flush, input logic exp_stall);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = rst_v;
        id_valid = vld;
        id_op    = ins.op;
        id_rs    = ins.rs;
        id_rt    = ins.rt;
        id_rd    = ins.rd;
        id_funct = ins.fn;
        ex_flush = flush;
        if (!rst_v) m_cnt = 0;
        e.idx         = step_idx;
        e.pc_write    = !exp_stall;
        e.ifid_write  = !exp_stall;
        e.ifid_flush  = flush;
        e.idex_bubble = exp_stall | flush | !vld;
        e.stall_cnt   = CNT_W'(m_cnt);
        exp_q.push_back(e);
        if (rst_v && exp_stall && m_cnt < int'(CNT_MAX)) m_cnt++;
        step_idx++;
    endtask

    task automatic run(input instr_t ins, input logic exp_stall);
        step(1'b1, 1'b1, ins, 1'b0, exp_stall);
    endtask

    task automatic hold(input instr_t ins, input int n_stall);
        for (int k = 0; k < n_stall; k++) run(ins, 1'b1);
        run(ins, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, mk(6'h00, 5'd0, 5'd0, 5'd0, 6'h00), 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc_write",    e.idx, int'(pc_write),    int'(e.pc_write));
            chk("ifid_write",  e.idx, int'(ifid_write),  int'(e.ifid_write));
            chk("ifid_flush",  e.idx, int'(ifid_flush),  int'(e.ifid_flush));
            chk("idex_bubble", e.idx, int'(idex_bubble), int'(e.idex_bubble));
            chk("stall_cnt",   e.idx, int'(stall_cnt),   int'(e.stall_cnt));
        end
    end

    initial begin
        instr_t lw8, beq8, add3, sub4, nop;
        rst = 1'b0; id_valid = 1'b0; id_op = '0; id_rs = '0; id_rt = '0;
        id_rd = '0; id_funct = '0; ex_flush = 1'b0;
        nop  = mk(6'h00, 5'd0, 5'd0, 5'd0, 6'h00);
        lw8  = mk(6'h23, 5'd9, 5'd8, 5'd0, 6'h00);   // lw  $8,0($9)
        beq8 = mk(6'h04, 5'd8, 5'd0, 5'd0, 6'h00);   // beq $8,$0
        add3 = mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h20);   // add $3,$1,$2
        sub4 = mk(6'h00, 5'd3, 5'd5, 5'd4, 6'h22);   // sub $4,$3,$5

        // Reset asserted in the middle of a load-use stall, then released.
        do_reset();
        run(lw8, 1'b0);
        run(beq8, 1'b1);
        step(1'b0, 1'b1, beq8, 1'b0, 1'b0);
        run(beq8, 1'b0);
        run(nop, 1'b0);

        // RAW through an ALU result.
        do_reset();
        run(add3, 1'b0);
        hold(sub4, ALU_STALLS);
        step(1'b1, 1'b0, nop, 1'b0, 1'b0);

        // Load-use.
        do_reset();
        run(lw8, 1'b0);
        hold(beq8, LOAD_STALLS);
        step(1'b1, 1'b0, nop, 1'b0, 1'b0);

        // $0 as destination and source.
        do_reset();
        run(mk(6'h08, 5'd0, 5'd0, 5'd0, 6'h05), 1'b0);   // addi $0,$0,5
        run(mk(6'h00, 5'd0, 5'd0, 5'd2, 6'h20), 1'b0);   // add  $2,$0,$0

        // j after a load, then a store reading the loaded register.
        do_reset();
        run(lw8, 1'b0);
        run(mk(6'h02, 5'd8, 5'd8, 5'd8, 6'h08), 1'b0);   // j (target bits alias $8)
        hold(mk(6'h2B, 5'd0, 5'd8, 5'd0, 6'h00), J_SW_STALLS);   // sw $8,0($0)

        // Invalid slot and jr ignore rt; jr records no destination.
        do_reset();
        run(lw8, 1'b0);
        step(1'b1, 1'b0, beq8, 1'b0, 1'b0);
        run(mk(6'h00, 5'd1, 5'd8, 5'd7, 6'h08), 1'b0);   // jr $1 (rt=8, rd=7 fields)
        run(mk(6'h00, 5'd7, 5'd0, 5'd9, 6'h20), 1'b0);   // add $9,$7,$0

        // Flush beats stall; squashed dst not recorded; older entry kept.
        do_reset();
        run(add3, 1'b0);
        step(1'b1, 1'b1, sub4, 1'b1, 1'b0);
        run(mk(6'h00, 5'd4, 5'd0, 5'd6, 6'h20), 1'b0);   // add $6,$4,$0
        hold(mk(6'h00, 5'd3, 5'd0, 5'd7, 6'h20), KEEP_STALLS);   // add $7,$3,$0

        // WAW: addi reloads the countdown left by an older load.
        do_reset();
        run(mk(6'h23, 5'd0, 5'd5, 5'd0, 6'h00), 1'b0);   // lw   $5,0($0)
        run(mk(6'h02, 5'd0, 5'd0, 5'd0, 6'h00), 1'b0);   // j
        run(mk(6'h02, 5'd0, 5'd0, 5'd0, 6'h00), 1'b0);   // j
        run(mk(6'h08, 5'd0, 5'd5, 5'd0, 6'h01), 1'b0);   // addi $5,$0,1
        hold(mk(6'h00, 5'd5, 5'd0, 5'd6, 6'h20), WAW_STALLS);   // add $6,$5,$0

        // Stall counter saturation.
        do_reset();
        for (int r = 0; r < 300; r++) begin
            run(mk(6'h23, 5'd0, 5'd1, 5'd0, 6'h00), 1'b0);   // lw  $1,0($0)
            hold(mk(6'h00, 5'd1, 5'd0, 5'd2, 6'h20), LOAD_STALLS);   // add $2,$1,$0
        end
        step(1'b1, 1'b0, nop, 1'b0, 1'b0);
        step(1'b1, 1'b0, nop, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        n_checks++;
        if (int'(stall_cnt) != int'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL stall_cnt_saturated: got %0d, expected %0d", stall_cnt, CNT_MAX);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
